// File: rtl/ram_dp_if.sv
// Bus bundle for the dual-port RAM.
// Port1 is a read-only instruction port and port2 is a read/write data port.
// Signal names carry the _i/_o direction as seen from the RAM (the slave side).
interface ram_dp_if #(
  parameter int DW = 32,
  parameter int AW = 16
);
  logic            ram_stb_i;
  logic [AW-1:0]   ram_addr_i;
  logic            ram_ack_o;
  logic [DW-1:0]   ram_data_o;
  logic            ram_err_o;

  logic            ram2_stb_i;
  logic            ram2_we_i;
  logic [DW/8-1:0] ram2_sel_i;
  logic [AW-1:0]   ram2_addr_i;
  logic [DW-1:0]   ram2_data_i;
  logic            ram2_ack_o;
  logic [DW-1:0]   ram2_data_o;
  logic            ram2_err_o;

  modport master (
    output ram_stb_i, ram_addr_i,
    output ram2_stb_i, ram2_we_i, ram2_sel_i, ram2_addr_i, ram2_data_i,
    input  ram_ack_o, ram_data_o, ram_err_o,
    input  ram2_ack_o, ram2_data_o, ram2_err_o
  );

  modport slave (
    input  ram_stb_i, ram_addr_i,
    input  ram2_stb_i, ram2_we_i, ram2_sel_i, ram2_addr_i, ram2_data_i,
    output ram_ack_o, ram_data_o, ram_err_o,
    output ram2_ack_o, ram2_data_o, ram2_err_o
  );
endinterface

// File: rtl/ram_dp.sv
// Dual-port single-clock RAM.
// Port1 reads only; port2 reads or writes with byte-lane enables.
// Both ports are fully pipelined: every sampled strobe gives exactly one ack
// RD_LAT cycles later. Addresses at or beyond DEPTH ack with err set, read as
// zero and never write. A port1 read colliding with a port2 write to the same
// word sees the new bytes (write-first). RD_LAT=2 adds a plain output register.
module ram_dp #(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 1
) (
  input logic     sys_clk,
  input logic     sys_rst_n,
  ram_dp_if.slave bus
);

  localparam int          NB      = DW / 8;
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          p1_in_range;
  logic          p2_in_range;
  logic          p2_wr_en;
  logic [IW-1:0] p1_idx;
  logic [IW-1:0] p2_idx;
  logic [DW-1:0] p2_lane_mask;
  logic [DW-1:0] p1_rd_word;
  logic [DW-1:0] p2_rd_word;

  // Decode ranges, build the lane mask and apply write-first bypass to port1
  always_comb begin
    p1_in_range  = ({1'b0, bus.ram_addr_i} < DEPTH_W);
    p2_in_range  = ({1'b0, bus.ram2_addr_i} < DEPTH_W);
    p1_idx       = bus.ram_addr_i[IW-1:0];
    p2_idx       = bus.ram2_addr_i[IW-1:0];
    p2_wr_en     = sys_rst_n && bus.ram2_stb_i && bus.ram2_we_i && p2_in_range;
    p2_lane_mask = '0;
    for (int k = 0; k < NB; k++) begin
      p2_lane_mask[8*k +: 8] = {8{bus.ram2_sel_i[k]}};
    end
    p2_rd_word = mem[p2_idx];
    p1_rd_word = mem[p1_idx];
    if (p2_wr_en && (p2_idx == p1_idx)) begin
      p1_rd_word = (p1_rd_word & ~p2_lane_mask) | (bus.ram2_data_i & p2_lane_mask);
    end
  end

  // Byte-lane writes from port2; the array itself is never reset
  always_ff @(posedge sys_clk) begin
    if (p2_wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.ram2_sel_i[k]) begin
          mem[p2_idx][8*k +: 8] <= bus.ram2_data_i[8*k +: 8];
        end
      end
    end
  end

  logic          p1_ack_q, p1_ack_d;
  logic          p1_err_q, p1_err_d;
  logic [DW-1:0] p1_data_q, p1_data_d;
  logic          p2_ack_q, p2_ack_d;
  logic          p2_err_q, p2_err_d;
  logic [DW-1:0] p2_data_q, p2_data_d;

  // First stage next-state: data only moves on a read so it holds between reads
  always_comb begin
    p1_ack_d  = bus.ram_stb_i;
    p1_err_d  = bus.ram_stb_i && !p1_in_range;
    p1_data_d = p1_data_q;
    if (bus.ram_stb_i) begin
      p1_data_d = p1_in_range ? p1_rd_word : '0;
    end

    p2_ack_d  = bus.ram2_stb_i;
    p2_err_d  = bus.ram2_stb_i && !p2_in_range;
    p2_data_d = p2_data_q;
    if (bus.ram2_stb_i && !bus.ram2_we_i) begin
      p2_data_d = p2_in_range ? p2_rd_word : '0;
    end
  end

  // First stage registers; reset drops anything in flight
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      p1_ack_q  <= 1'b0;
      p1_err_q  <= 1'b0;
      p1_data_q <= '0;
      p2_ack_q  <= 1'b0;
      p2_err_q  <= 1'b0;
      p2_data_q <= '0;
    end else begin
      p1_ack_q  <= p1_ack_d;
      p1_err_q  <= p1_err_d;
      p1_data_q <= p1_data_d;
      p2_ack_q  <= p2_ack_d;
      p2_err_q  <= p2_err_d;
      p2_data_q <= p2_data_d;
    end
  end

  if (RD_LAT == 2) begin : g_out_reg
    logic          o1_ack_q, o1_ack_d;
    logic          o1_err_q, o1_err_d;
    logic [DW-1:0] o1_data_q, o1_data_d;
    logic          o2_ack_q, o2_ack_d;
    logic          o2_err_q, o2_err_d;
    logic [DW-1:0] o2_data_q, o2_data_d;

    // Output stage copies stage one, which already holds data between reads
    always_comb begin
      o1_ack_d  = p1_ack_q;
      o1_err_d  = p1_err_q;
      o1_data_d = p1_data_q;
      o2_ack_d  = p2_ack_q;
      o2_err_d  = p2_err_q;
      o2_data_d = p2_data_q;
    end

    // Output stage registers, cleared with the rest of the pipeline
    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        o1_ack_q  <= 1'b0;
        o1_err_q  <= 1'b0;
        o1_data_q <= '0;
        o2_ack_q  <= 1'b0;
        o2_err_q  <= 1'b0;
        o2_data_q <= '0;
      end else begin
        o1_ack_q  <= o1_ack_d;
        o1_err_q  <= o1_err_d;
        o1_data_q <= o1_data_d;
        o2_ack_q  <= o2_ack_d;
        o2_err_q  <= o2_err_d;
        o2_data_q <= o2_data_d;
      end
    end

    assign bus.ram_ack_o   = o1_ack_q;
    assign bus.ram_err_o   = o1_err_q;
    assign bus.ram_data_o  = o1_data_q;
    assign bus.ram2_ack_o  = o2_ack_q;
    assign bus.ram2_err_o  = o2_err_q;
    assign bus.ram2_data_o = o2_data_q;
  end else begin : g_no_out_reg
    assign bus.ram_ack_o   = p1_ack_q;
    assign bus.ram_err_o   = p1_err_q;
    assign bus.ram_data_o  = p1_data_q;
    assign bus.ram2_ack_o  = p2_ack_q;
    assign bus.ram2_err_o  = p2_err_q;
    assign bus.ram2_data_o = p2_data_q;
  end

endmodule

// File: tb/tb_ram_dp.sv
// Testbench for ram_dp.
// Two instances share one stimulus: lat1 (RD_LAT=1) is checked against a
// vector table, lat2 (RD_LAT=2) against hand-written pipeline sequences.
module tb_ram_dp;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 512;

  typedef struct {
    logic        p1_stb;
    logic [15:0] p1_addr;
    logic        p2_stb;
    logic        p2_we;
    logic [3:0]  p2_sel;
    logic [15:0] p2_addr;
    logic [31:0] p2_wdata;
    logic        exp_ack1;
    logic [31:0] exp_data1;
    logic        exp_err1;
    logic        exp_ack2;
    logic [31:0] exp_data2;
    logic        exp_err2;
  } vec_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          stb1;
  logic [AW-1:0] addr1;
  logic          stb2;
  logic          we2;
  logic [3:0]    sel2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata2;

  int checks = 0;
  int errors = 0;

  vec_t vecs[19];

  ram_dp_if #(.DW(DW), .AW(AW)) bus_l1 ();
  ram_dp_if #(.DW(DW), .AW(AW)) bus_l2 ();

  assign bus_l1.ram_stb_i   = stb1;
  assign bus_l1.ram_addr_i  = addr1;
  assign bus_l1.ram2_stb_i  = stb2;
  assign bus_l1.ram2_we_i   = we2;
  assign bus_l1.ram2_sel_i  = sel2;
  assign bus_l1.ram2_addr_i = addr2;
  assign bus_l1.ram2_data_i = wdata2;

  assign bus_l2.ram_stb_i   = stb1;
  assign bus_l2.ram_addr_i  = addr1;
  assign bus_l2.ram2_stb_i  = stb2;
  assign bus_l2.ram2_we_i   = we2;
  assign bus_l2.ram2_sel_i  = sel2;
  assign bus_l2.ram2_addr_i = addr2;
  assign bus_l2.ram2_data_i = wdata2;

  ram_dp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(1)) dut_lat1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_l1.slave)
  );

  ram_dp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(2)) dut_lat2 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_l2.slave)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic vec_t make_vec(
    input logic p1_stb, input logic [15:0] p1_addr,
    input logic p2_stb, input logic p2_we, input logic [3:0] p2_sel,
    input logic [15:0] p2_addr, input logic [31:0] p2_wdata,
    input logic a1, input logic [31:0] d1, input logic e1,
    input logic a2, input logic [31:0] d2, input logic e2);
    vec_t v;
    v.p1_stb = p1_stb;  v.p1_addr = p1_addr;
    v.p2_stb = p2_stb;  v.p2_we = p2_we;  v.p2_sel = p2_sel;
    v.p2_addr = p2_addr; v.p2_wdata = p2_wdata;
    v.exp_ack1 = a1; v.exp_data1 = d1; v.exp_err1 = e1;
    v.exp_ack2 = a2; v.exp_data2 = d2; v.exp_err2 = e2;
    return v;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic p1_stb, input logic [15:0] p1_addr,
                                input logic p2_stb, input logic p2_we, input logic [3:0] p2_sel,
                                input logic [15:0] p2_addr, input logic [31:0] p2_wdata);
    stb1   = p1_stb;
    addr1  = p1_addr;
    stb2   = p2_stb;
    we2    = p2_we;
    sel2   = p2_sel;
    addr2  = p2_addr;
    wdata2 = p2_wdata;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " l1 ack1"},  32'(bus_l1.ram_ack_o),  32'h0);
    check_output({tag, " l1 err1"},  32'(bus_l1.ram_err_o),  32'h0);
    check_output({tag, " l1 data1"}, bus_l1.ram_data_o,      32'h0);
    check_output({tag, " l1 ack2"},  32'(bus_l1.ram2_ack_o), 32'h0);
    check_output({tag, " l1 err2"},  32'(bus_l1.ram2_err_o), 32'h0);
    check_output({tag, " l1 data2"}, bus_l1.ram2_data_o,     32'h0);
    check_output({tag, " l2 ack1"},  32'(bus_l2.ram_ack_o),  32'h0);
    check_output({tag, " l2 err1"},  32'(bus_l2.ram_err_o),  32'h0);
    check_output({tag, " l2 data1"}, bus_l2.ram_data_o,      32'h0);
    check_output({tag, " l2 ack2"},  32'(bus_l2.ram2_ack_o), 32'h0);
    check_output({tag, " l2 err2"},  32'(bus_l2.ram2_err_o), 32'h0);
    check_output({tag, " l2 data2"}, bus_l2.ram2_data_o,     32'h0);
  endtask

  initial begin
    logic [31:0] seq_mem [4];

    // p1 stb/addr, p2 stb/we/sel/addr/wdata, then expected ack/data/err for port1 and port2
    vecs[0]  = make_vec(0, 16'd0,      1, 1, 4'hF, 16'd0,   32'h00000000, 0, 32'h00000000, 0, 1, 32'h00000000, 0);
    vecs[1]  = make_vec(1, 16'd0,      1, 1, 4'hF, 16'd1,   32'h01010101, 1, 32'h00000000, 0, 1, 32'h00000000, 0);
    vecs[2]  = make_vec(1, 16'd1,      1, 1, 4'hF, 16'd2,   32'h02020202, 1, 32'h01010101, 0, 1, 32'h00000000, 0);
    vecs[3]  = make_vec(1, 16'd2,      1, 1, 4'hF, 16'd3,   32'h03030303, 1, 32'h02020202, 0, 1, 32'h00000000, 0);
    vecs[4]  = make_vec(1, 16'd3,      1, 1, 4'hF, 16'd7,   32'h11223344, 1, 32'h03030303, 0, 1, 32'h00000000, 0);
    vecs[5]  = make_vec(0, 16'd0,      1, 1, 4'hF, 16'd9,   32'h00000000, 0, 32'h03030303, 0, 1, 32'h00000000, 0);
    vecs[6]  = make_vec(0, 16'd0,      1, 1, 4'hF, 16'd5,   32'hDEADBEEF, 0, 32'h03030303, 0, 1, 32'h00000000, 0);
    vecs[7]  = make_vec(1, 16'd5,      1, 1, 4'h5, 16'd7,   32'hAABBCCDD, 1, 32'hDEADBEEF, 0, 1, 32'h00000000, 0);
    vecs[8]  = make_vec(0, 16'd0,      1, 0, 4'hA, 16'd7,   32'hFFFFFFFF, 0, 32'hDEADBEEF, 0, 1, 32'h11BB33DD, 0);
    vecs[9]  = make_vec(1, 16'd9,      1, 1, 4'hF, 16'd9,   32'h12345678, 1, 32'h12345678, 0, 1, 32'h11BB33DD, 0);
    vecs[10] = make_vec(1, 16'd9,      1, 1, 4'h3, 16'd9,   32'hAAAAAAAA, 1, 32'h1234AAAA, 0, 1, 32'h11BB33DD, 0);
    vecs[11] = make_vec(1, 16'd9,      1, 0, 4'h0, 16'd9,   32'h00000000, 1, 32'h1234AAAA, 0, 1, 32'h1234AAAA, 0);
    vecs[12] = make_vec(0, 16'd0,      1, 1, 4'h0, 16'd9,   32'hFFFFFFFF, 0, 32'h1234AAAA, 0, 1, 32'h1234AAAA, 0);
    vecs[13] = make_vec(1, 16'd512,    1, 0, 4'h0, 16'd9,   32'h00000000, 1, 32'h00000000, 1, 1, 32'h1234AAAA, 0);
    vecs[14] = make_vec(0, 16'd0,      1, 1, 4'hF, 16'd512, 32'hFFFFFFFF, 0, 32'h00000000, 0, 1, 32'h1234AAAA, 1);
    vecs[15] = make_vec(1, 16'd0,      1, 0, 4'h0, 16'd512, 32'h00000000, 1, 32'h00000000, 0, 1, 32'h00000000, 1);
    vecs[16] = make_vec(1, 16'hFFFF,   1, 1, 4'hF, 16'd511, 32'h5A5A5A5A, 1, 32'h00000000, 1, 1, 32'h00000000, 0);
    vecs[17] = make_vec(1, 16'd511,    1, 0, 4'h0, 16'd511, 32'h00000000, 1, 32'h5A5A5A5A, 0, 1, 32'h5A5A5A5A, 0);
    vecs[18] = make_vec(0, 16'd0,      0, 0, 4'h0, 16'd0,   32'h00000000, 0, 32'h5A5A5A5A, 0, 0, 32'h5A5A5A5A, 0);

    seq_mem[0] = 32'h00000000;
    seq_mem[1] = 32'h01010101;
    seq_mem[2] = 32'h02020202;
    seq_mem[3] = 32'h03030303;

    // Reset with idle bus: every output of both instances must be zero
    sys_rst_n = 1'b0;
    apply_stimulus(0, 16'd0, 0, 0, 4'h0, 16'd0, 32'h0);
    step();
    step();
    check_all_zero("reset");
    sys_rst_n = 1'b1;

    // Table of single-cycle transactions against the RD_LAT=1 instance
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].p1_stb, vecs[i].p1_addr, vecs[i].p2_stb, vecs[i].p2_we,
                     vecs[i].p2_sel, vecs[i].p2_addr, vecs[i].p2_wdata);
      step();
      check_output($sformatf("v%0d ack1", i),  32'(bus_l1.ram_ack_o),  32'(vecs[i].exp_ack1));
      check_output($sformatf("v%0d data1", i), bus_l1.ram_data_o,      vecs[i].exp_data1);
      check_output($sformatf("v%0d err1", i),  32'(bus_l1.ram_err_o),  32'(vecs[i].exp_err1));
      check_output($sformatf("v%0d ack2", i),  32'(bus_l1.ram2_ack_o), 32'(vecs[i].exp_ack2));
      check_output($sformatf("v%0d data2", i), bus_l1.ram2_data_o,     vecs[i].exp_data2);
      check_output($sformatf("v%0d err2", i),  32'(bus_l1.ram2_err_o), 32'(vecs[i].exp_err2));
    end

    // Back-to-back port1 reads 0..3 then one out-of-range; lat2 trails lat1 by a cycle
    for (int t = 0; t < 7; t++) begin
      apply_stimulus(t < 5, (t < 4) ? 16'(t) : 16'd600, 0, 0, 4'h0, 16'd0, 32'h0);
      step();
      check_output($sformatf("b2b t%0d l1 ack", t), 32'(bus_l1.ram_ack_o), 32'(t <= 4));
      check_output($sformatf("b2b t%0d l1 err", t), 32'(bus_l1.ram_err_o), 32'(t == 4));
      if (t <= 4) begin
        check_output($sformatf("b2b t%0d l1 data", t), bus_l1.ram_data_o, (t < 4) ? seq_mem[t] : 32'h0);
      end
      check_output($sformatf("b2b t%0d l2 ack", t), 32'(bus_l2.ram_ack_o), 32'(t >= 1 && t <= 5));
      check_output($sformatf("b2b t%0d l2 err", t), 32'(bus_l2.ram_err_o), 32'(t == 5));
      if (t >= 1 && t <= 5) begin
        check_output($sformatf("b2b t%0d l2 data", t), bus_l2.ram_data_o, (t < 5) ? seq_mem[t-1] : 32'h0);
      end
    end

    // Port2 read of addr 5, then reset for two edges while a write to 5 is presented
    apply_stimulus(0, 16'd0, 1, 0, 4'h0, 16'd5, 32'h0);
    step();
    check_output("rst pre l1 ack2", 32'(bus_l1.ram2_ack_o), 32'h1);
    check_output("rst pre l1 data2", bus_l1.ram2_data_o, 32'hDEADBEEF);
    sys_rst_n = 1'b0;
    apply_stimulus(1, 16'd5, 1, 1, 4'hF, 16'd5, 32'h0BADF00D);
    step();
    check_all_zero("rst e1");
    step();
    check_all_zero("rst e2");
    sys_rst_n = 1'b1;
    apply_stimulus(0, 16'd0, 0, 0, 4'h0, 16'd0, 32'h0);
    step();
    check_output("rst post1 l2 ack1", 32'(bus_l2.ram_ack_o),  32'h0);
    check_output("rst post1 l2 ack2", 32'(bus_l2.ram2_ack_o), 32'h0);
    check_output("rst post1 l1 ack2", 32'(bus_l1.ram2_ack_o), 32'h0);
    step();
    check_output("rst post2 l2 ack2", 32'(bus_l2.ram2_ack_o), 32'h0);

    // First requests after release; memory must still hold the pre-reset write
    apply_stimulus(1, 16'd5, 1, 0, 4'h0, 16'd5, 32'h0);
    step();
    check_output("rel l1 ack1",  32'(bus_l1.ram_ack_o),  32'h1);
    check_output("rel l1 data1", bus_l1.ram_data_o,      32'hDEADBEEF);
    check_output("rel l1 ack2",  32'(bus_l1.ram2_ack_o), 32'h1);
    check_output("rel l1 data2", bus_l1.ram2_data_o,     32'hDEADBEEF);
    check_output("rel l2 ack1 early", 32'(bus_l2.ram_ack_o), 32'h0);
    apply_stimulus(0, 16'd0, 0, 0, 4'h0, 16'd0, 32'h0);
    step();
    check_output("rel l1 ack1 off", 32'(bus_l1.ram_ack_o), 32'h0);
    check_output("rel l2 ack1",  32'(bus_l2.ram_ack_o),  32'h1);
    check_output("rel l2 data1", bus_l2.ram_data_o,      32'hDEADBEEF);
    check_output("rel l2 ack2",  32'(bus_l2.ram2_ack_o), 32'h1);
    check_output("rel l2 data2", bus_l2.ram2_data_o,     32'hDEADBEEF);
    check_output("rel l2 err2",  32'(bus_l2.ram2_err_o), 32'h0);
    step();
    check_output("rel l2 ack1 off", 32'(bus_l2.ram_ack_o), 32'h0);
    check_output("rel l2 data1 hold", bus_l2.ram_data_o, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
